// File: rtl/gray_dekoder_pipe.sv
// Gray-to-binary decode stage with error flagging and a saturating error counter; 1-cycle latency,
// full throughput, o_ready = !o_valid || i_ready. Step check guarded by macro GRAY_STEP_CHK_EN.
module gray_dekoder_pipe #(
   parameter int LEN   = 4,
   parameter int CNT_W = 8
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_valid,
   output logic             o_ready,
   input  logic [LEN-1:0]   i_gray,
   output logic             o_valid,
   input  logic             i_ready,
   output logic [LEN-1:0]   o_data,
   output logic             o_err,
   output logic             o_step_err,
   output logic [CNT_W-1:0] o_err_cnt,
   input  logic             i_clr_cnt
);
   logic             r_valid;
   logic [LEN-1:0]   r_data;
   logic             r_err;
   logic [CNT_W-1:0] r_err_cnt;
   logic             w_ready;
   logic             w_accept;
   logic             w_is_err;
   logic [LEN-1:0]   w_bin;
   logic [LEN-1:0]   w_word;

   assign w_ready  = !r_valid || i_ready;
   assign w_accept = i_valid && w_ready;
   assign w_is_err = i_gray[LEN-1];

   // Each binary bit is the XOR of all Gray bits at or above it.
   always_comb begin
      w_bin = '0;
      for (int i = 0; i < LEN; i++) begin
         w_bin[i] = ^(i_gray >> i);
      end
   end

   assign w_word = w_is_err ? '1 : w_bin;

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_valid   <= 1'b0;
         r_data    <= '0;
         r_err     <= 1'b0;
         r_err_cnt <= '0;
      end else begin
         if (w_accept) begin
            r_valid <= 1'b1;
            r_data  <= w_word;
            r_err   <= w_is_err;
         end else if (i_ready) begin
            r_valid <= 1'b0;
         end
         // Clear wins over a simultaneous error increment.
         if (i_clr_cnt) begin
            r_err_cnt <= '0;
         end else if (w_accept && w_is_err && (r_err_cnt != '1)) begin
            r_err_cnt <= r_err_cnt + CNT_W'(1);
         end
      end
   end

`ifdef GRAY_STEP_CHK_EN
   logic [LEN-1:0] r_prev;
   logic           r_have_prev;
   logic           r_step_err;
   logic [LEN-1:0] w_diff;
   logic           w_one_hot;

   assign w_diff    = i_gray ^ r_prev;
   assign w_one_hot = (w_diff != '0) && ((w_diff & (w_diff - LEN'(1))) == '0);

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_prev      <= '0;
         r_have_prev <= 1'b0;
         r_step_err  <= 1'b0;
      end else if (w_accept) begin
         r_step_err <= !w_is_err && r_have_prev && !w_one_hot;
         // Error words never become the reference for the next step.
         if (!w_is_err) begin
            r_prev      <= i_gray;
            r_have_prev <= 1'b1;
         end
      end
   end

   assign o_step_err = r_step_err;
`else
   assign o_step_err = 1'b0;
`endif

   assign o_ready   = w_ready;
   assign o_valid   = r_valid;
   assign o_data    = r_data;
   assign o_err     = r_err;
   assign o_err_cnt = r_err_cnt;
endmodule

// File: tb/tb_gray_dekoder_pipe.sv
// Bench for gray_dekoder_pipe: directed cases then random traffic against a transaction-level model.
module tb_gray_dekoder_pipe;
   localparam int LEN   = 4;
   localparam int CNT_W = 2;
`ifdef GRAY_STEP_CHK_EN
   localparam bit STEP_EN = 1'b1;
`else
   localparam bit STEP_EN = 1'b0;
`endif

   typedef struct {
      logic [LEN-1:0] data;
      logic           err;
      logic           step;
   } word_t;

   logic             clk = 1'b0;
   logic             rst_n;
   logic             valid_in;
   logic             ready_out;
   logic [LEN-1:0]   gray_in;
   logic             valid_out;
   logic             ready_in;
   logic [LEN-1:0]   data_out;
   logic             err_out;
   logic             step_out;
   logic [CNT_W-1:0] cnt_out;
   logic             clr_cnt;

   int total = 0;
   int bad   = 0;

   word_t          q[$];
   word_t          last;
   int             m_cnt;
   logic [LEN-1:0] m_prev;
   bit             m_have;

   gray_dekoder_pipe #(.LEN(LEN), .CNT_W(CNT_W)) dut (
      .i_clk(clk), .i_rst_n(rst_n), .i_valid(valid_in), .o_ready(ready_out),
      .i_gray(gray_in), .o_valid(valid_out), .i_ready(ready_in), .o_data(data_out),
      .o_err(err_out), .o_step_err(step_out), .o_err_cnt(cnt_out), .i_clr_cnt(clr_cnt)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h (t=%0t)", tag, act, exp, $time);
      end
   endtask

   // Binary value whose Gray code equals g, found by search.
   function automatic logic [LEN-1:0] inv_gray(input logic [LEN-1:0] g);
      for (int v = 0; v < (1 << LEN); v++) begin
         if ((v ^ (v >> 1)) == int'(g)) return LEN'(v);
      end
      return '0;
   endfunction

   function automatic word_t expect_word(input logic [LEN-1:0] g);
      word_t w;
      if (g[LEN-1]) begin
         w.data = '1;
         w.err  = 1'b1;
         w.step = 1'b0;
      end else begin
         w.data = inv_gray(g);
         w.err  = 1'b0;
         w.step = STEP_EN && m_have && ($countones(g ^ m_prev) != 1);
      end
      return w;
   endfunction

   // One clock: drive at negedge, check outputs, then apply model at posedge.
   task automatic cyc(input logic v, input logic [LEN-1:0] g, input logic rdy,
                      input logic clr, input logic rn);
      bit acc;
      bit cons;
      valid_in = v;
      gray_in  = g;
      ready_in = rdy;
      clr_cnt  = clr;
      rst_n    = rn;
      #1;
      chk("ready", ready_out, (q.size() == 0) || rdy);
      chk("valid", valid_out, q.size() != 0);
      chk("data", data_out, q.size() != 0 ? q[0].data : last.data);
      chk("err", err_out, q.size() != 0 ? q[0].err : last.err);
      chk("step", step_out, q.size() != 0 ? q[0].step : last.step);
      chk("cnt", cnt_out, m_cnt);
      @(posedge clk);
      if (!rn) begin
         q.delete();
         last   = '{data: '0, err: 1'b0, step: 1'b0};
         m_cnt  = 0;
         m_have = 0;
         m_prev = '0;
      end else begin
         cons = (q.size() != 0) && rdy;
         acc  = v && ((q.size() == 0) || rdy);
         if (cons) void'(q.pop_front());
         if (acc) begin
            word_t w;
            w = expect_word(g);
            q.push_back(w);
            last = w;
            if (!g[LEN-1]) begin
               m_prev = g;
               m_have = 1;
            end
         end
         if (clr) m_cnt = 0;
         else if (acc && g[LEN-1] && m_cnt < (1 << CNT_W) - 1) m_cnt++;
      end
      @(negedge clk);
   endtask

   initial begin
      logic [LEN-1:0] g;
      valid_in = 1'b0;
      gray_in  = '0;
      ready_in = 1'b1;
      clr_cnt  = 1'b0;
      rst_n    = 1'b0;
      last     = '{data: '0, err: 1'b0, step: 1'b0};
      m_cnt    = 0;
      m_have   = 0;
      m_prev   = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      chk("rst_valid", valid_out, 0);
      chk("rst_data", data_out, 0);
      chk("rst_err", err_out, 0);
      chk("rst_step", step_out, 0);
      chk("rst_cnt", cnt_out, 0);

      // single word, then step sequence incl. error word
      cyc(1, 4'b0110, 1, 0, 1);
      cyc(1, 4'b0111, 1, 0, 1);
      cyc(1, 4'b0100, 1, 0, 1);
      cyc(1, 4'b1111, 1, 0, 1);
      cyc(1, 4'b0101, 1, 0, 1);
      cyc(1, 4'b0101, 1, 0, 1);
      cyc(0, 4'b0000, 1, 0, 1);
      // saturation and clear priority
      repeat (4) cyc(1, 4'b1111, 1, 0, 1);
      cyc(1, 4'b1010, 1, 0, 1);
      cyc(1, 4'b1111, 1, 1, 1);
      cyc(0, 4'b1111, 1, 0, 1);
      // backpressure
      cyc(1, 4'b0110, 1, 0, 1);
      repeat (3) cyc(1, 4'b0111, 0, 0, 1);
      cyc(1, 4'b0111, 1, 0, 1);
      cyc(0, 4'b0000, 1, 0, 1);
      cyc(0, 4'b0000, 1, 0, 1);
      // full-throughput stream
      cyc(1, 4'b0000, 1, 0, 1);
      cyc(1, 4'b0001, 1, 0, 1);
      cyc(1, 4'b0011, 1, 0, 1);
      cyc(1, 4'b0010, 1, 0, 1);
      cyc(0, 4'b0000, 1, 0, 1);
      // reset mid-stall
      cyc(1, 4'b1111, 1, 0, 1);
      cyc(1, 4'b0011, 0, 0, 1);
      cyc(1, 4'b0011, 0, 0, 0);
      cyc(1, 4'b0010, 1, 0, 1);
      cyc(0, 4'b0000, 1, 0, 1);

      for (int n = 0; n < 3000; n++) begin
         case ($urandom_range(3))
            0: g = LEN'($urandom_range((1 << LEN) - 1));
            1: g = {1'b1, (LEN-1)'($urandom)};
            default: g = m_prev ^ LEN'(1 << $urandom_range(LEN - 2));
         endcase
         cyc($urandom_range(3) != 0, g, $urandom_range(2) != 0,
             $urandom_range(39) == 0, $urandom_range(99) != 0);
      end
      cyc(0, 4'b0000, 1, 0, 1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
